pc_fetch_unit: RTL and testbench

- Holds the architectural PC and fetches each instruction word from instruction memory over a req/ack handshake.
- Consumes the branch and jump targets produced by the immediate/target extension stage, plus the register jump target, to choose the next PC.
- Drives npc (PC+4) back to that stage, closing the PC loop of the single-cycle CPU.
- Sits between instruction memory and decode/EXT.

---
 rtl/pc_fetch_pkg.sv | 28 ++
 rtl/pc_fetch_unit_npc_sel.sv | 55 +++++
 rtl/pc_fetch_unit.sv | 138 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and defaults for the PC/fetch unit.
//   - state_e     : fetch FSM encoding (StIdle=0, StReq=1, StHold=2)
//   - next_sel_e  : next-PC source select (SelSeq, SelBr, SelJ, SelJr)
//   - PC_RESET_DEFAULT / EXC_VECTOR_DEFAULT : default reset PC and exception vector
//   - word_align  : clears the two low address bits
package pc_fetch_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StHold = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SelSeq = 2'd0,
      SelBr  = 2'd1,
      SelJ   = 2'd2,
      SelJr  = 2'd3
   } next_sel_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_sel.sv
// npc_sel: combinational next-PC priority mux.
// Ports:
//   pc            in  32  current PC
//   branch_en     in   1  select branch_target
//   branch_target in  32  branch target
//   jump_en       in   1  select jump_target
//   jump_target   in  32  j/jal target
//   jr_en         in   1  select jr_target (highest priority)
//   jr_target     in  32  register jump target
//   npc           out 32  pc + 4 (wraps modulo 2^32)
//   next_pc       out 32  selected next PC, low bits untouched
//   misalign      out  1  next_pc[1:0] != 0
module npc_sel
   import pc_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic [31:0] npc,
   output logic [31:0] next_pc,
   output logic        misalign
);

   next_sel_e sel;

   assign npc = pc + 32'd4;

   always_comb begin
      sel = SelSeq;
      if (jr_en) begin
         sel = SelJr;
      end else if (jump_en) begin
         sel = SelJ;
      end else if (branch_en) begin
         sel = SelBr;
      end
   end

   always_comb begin
      next_pc = npc;
      unique case (sel)
         SelJr:   next_pc = jr_target;
         SelJ:    next_pc = jump_target;
         SelBr:   next_pc = branch_target;
         default: next_pc = npc;
      endcase
   end

   assign misalign = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC and fetches instruction words over a
// req/ack handshake (IDLE -> REQ -> HOLD -> REQ ...), two cycles per instruction minimum.
// Optional macro PC_ALIGN_CHK_EN: a misaligned next PC loads EXC_VECTOR and pulses adel;
// without it the low two bits of next PC are cleared and adel is tied 0.
// Ports:
//   clk, reset (async, active-low)
//   stall                 hold the current instruction in HOLD
//   branch_en/_target, jump_en/_target, jr_en/_target : redirect sources (jr > j > br)
//   imem_req/addr/ack/rdata : instruction memory handshake
//   instr, instr_valid    held instruction for decode
//   pc, npc               current PC and pc + 4
//   adel                  one-cycle misaligned-target pulse
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT
`ifdef PC_ALIGN_CHK_EN
   ,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        adel
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] next_pc;
   logic        misalign;

   npc_sel u_npc_sel (
      .pc            (pc_q),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .jr_en         (jr_en),
      .jr_target     (jr_target),
      .npc           (npc),
      .next_pc       (next_pc),
      .misalign      (misalign)
   );

`ifdef PC_ALIGN_CHK_EN
   logic adel_q, adel_d;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
`ifdef PC_ALIGN_CHK_EN
      adel_d  = 1'b0;
`endif
      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            // stall is deliberately not looked at here; a fetch always completes
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (!stall) begin
               valid_d = 1'b0;
               state_d = StReq;
`ifdef PC_ALIGN_CHK_EN
               // check the raw target before any masking
               if (misalign) begin
                  pc_d   = EXC_VECTOR;
                  adel_d = 1'b1;
               end else begin
                  pc_d = next_pc;
               end
`else
               pc_d = misalign ? word_align(next_pc) : next_pc;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         pc_q    <= PC_RESET;
         instr_q <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

`ifdef PC_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         adel_q <= 1'b0;
      end else begin
         adel_q <= adel_d;
      end
   end
   assign adel = adel_q;
`else
   assign adel = 1'b0;
`endif

   assign imem_req    = (state_q == StReq);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump_en = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        jr_en = 1'b0;
   logic [31:0] jr_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b1;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        adel;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   // memory returns a word derived from the address so latched data is traceable
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   pc_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .jr_en         (jr_en),
      .jr_target     (jr_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .npc           (npc),
      .adel          (adel)
   );

   // Waits (bounded) for a negedge with imem_req high.
   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL req_timeout: imem_req never rose, got %b want 1", imem_req);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (pc !== 32'h0000_3000) begin n_fail++;
         $display("FAIL rst_pc: got %h want 00003000", pc); end
      n_cmp++; if (imem_req !== 1'b0) begin n_fail++;
         $display("FAIL rst_req: got %b want 0", imem_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_fail++;
         $display("FAIL rst_valid: got %b want 0", instr_valid); end
      n_cmp++; if (instr !== 32'h0) begin n_fail++;
         $display("FAIL rst_instr: got %h want 00000000", instr); end
      n_cmp++; if (adel !== 1'b0) begin n_fail++;
         $display("FAIL rst_adel: got %b want 0", adel); end
      n_cmp++; if (npc !== 32'h0000_3004) begin n_fail++;
         $display("FAIL rst_npc: got %h want 00003004", npc); end
   endtask

   task automatic test_sequential();
      bit ok;
      logic [31:0] e;
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_3000 + 32'(i * 4));
      reset = 1'b1;
      // first REQ must appear exactly one edge after release
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1) begin n_fail++;
         $display("FAIL seq_first_req: got %b want 1", imem_req); end
      for (int i = 0; i < 3; i++) begin
         if (i != 0) wait_req(ok);
         e = exp_q.pop_front();
         n_cmp++; if (imem_addr !== e) begin n_fail++;
            $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, e); end
         @(negedge clk);
         n_cmp++; if (instr_valid !== 1'b1 || instr !== mem_word(e)) begin n_fail++;
            $display("FAIL seq_instr%0d: got %b/%h want 1/%h", i, instr_valid, instr,
                     mem_word(e)); end
      end
   endtask

   task automatic test_priority();
      bit ok;
      logic [31:0] e;
      // jump beats branch
      branch_en = 1'b1; branch_target = 32'h0000_3020;
      jump_en   = 1'b1; jump_target   = 32'h0000_3100;
      exp_q.push_back(32'h0000_3100);
      wait_req(ok);
      e = exp_q.pop_front();
      n_cmp++; if (imem_addr !== e) begin n_fail++;
         $display("FAIL prio_jump: got %h want %h", imem_addr, e); end
      @(negedge clk);
      // jr beats jump and branch
      jr_en = 1'b1; jr_target = 32'h0000_3200;
      exp_q.push_back(32'h0000_3200);
      wait_req(ok);
      branch_en = 1'b0; jump_en = 1'b0; jr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (imem_addr !== e) begin n_fail++;
         $display("FAIL prio_jr: got %h want %h", imem_addr, e); end
      @(negedge clk);
      n_cmp++; if (instr !== mem_word(e)) begin n_fail++;
         $display("FAIL prio_instr: got %h want %h", instr, mem_word(e)); end
   endtask

   task automatic test_stall();
      bit ok;
      logic [31:0] e;
      stall = 1'b1;
      branch_en = 1'b1; branch_target = 32'h0000_3300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (pc !== 32'h0000_3200 || instr_valid !== 1'b1 || instr !== mem_word(32'h3200)
             || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got pc=%h v=%b i=%h r=%b want 3200/1/%h/0", i, pc,
                     instr_valid, instr, imem_req, mem_word(32'h3200));
         end
      end
      stall = 1'b0;
      exp_q.push_back(32'h0000_3300);
      wait_req(ok);
      branch_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (imem_addr !== e) begin n_fail++;
         $display("FAIL stall_release: got %h want %h", imem_addr, e); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fetch();
      bit ok;
      logic [31:0] e;
      imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3304) begin n_fail++;
            $display("FAIL wait_stable%0d: got %b/%h want 1/00003304", i, imem_req,
                     imem_addr); end
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b0 || pc !== 32'h0000_3000) begin n_fail++;
         $display("FAIL async_reset: got %b/%h want 0/00003000", imem_req, pc); end
      imem_ack = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_fail++;
         $display("FAIL late_ack: got %b/%h want 0/00000000", instr_valid, instr); end
      exp_q.push_back(32'h0000_3000);
      wait_req(ok);
      e = exp_q.pop_front();
      n_cmp++; if (imem_addr !== e) begin n_fail++;
         $display("FAIL refetch_addr: got %h want %h", imem_addr, e); end
      @(negedge clk);
      n_cmp++; if (instr_valid !== 1'b1 || instr !== mem_word(e)) begin n_fail++;
         $display("FAIL refetch_instr: got %b/%h want 1/%h", instr_valid, instr,
                  mem_word(e)); end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] e;
      jr_en = 1'b1; jr_target = 32'hFFFF_FFFC;
      exp_q.push_back(32'hFFFF_FFFC);
      wait_req(ok);
      jr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (imem_addr !== e) begin n_fail++;
         $display("FAIL wrap_top: got %h want %h", imem_addr, e); end
      n_cmp++; if (npc !== 32'h0000_0000) begin n_fail++;
         $display("FAIL wrap_npc: got %h want 00000000", npc); end
      @(negedge clk);
      exp_q.push_back(32'h0000_0000);
      wait_req(ok);
      e = exp_q.pop_front();
      n_cmp++; if (imem_addr !== e) begin n_fail++;
         $display("FAIL wrap_fetch: got %h want %h", imem_addr, e); end
      @(negedge clk);
   endtask

   task automatic test_align();
      bit ok;
      logic [31:0] e;
      logic        exp_adel;
`ifdef PC_ALIGN_CHK_EN
      exp_adel = 1'b1;
      exp_q.push_back(32'h0000_4180);
`else
      exp_adel = 1'b0;
      exp_q.push_back(32'h0000_3000);
`endif
      jr_en = 1'b1; jr_target = 32'h0000_3002;
      wait_req(ok);
      jr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (pc !== e) begin n_fail++;
         $display("FAIL align_pc: got %h want %h", pc, e); end
      n_cmp++; if (adel !== exp_adel) begin n_fail++;
         $display("FAIL align_adel: got %b want %b", adel, exp_adel); end
      @(negedge clk);
      n_cmp++; if (adel !== 1'b0) begin n_fail++;
         $display("FAIL align_adel_pulse: got %b want 0", adel); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_priority();
      test_stall();
      test_reset_mid_fetch();
      test_wrap();
      test_align();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
